cond_flag_register: RTL and testbench
=====================================

Name: cond_flag_register

Overview:
- Sequential front half of the execute-stage conditional unit.
- Holds the architectural NZCV flag register that feeds the condition checker's Flags input.
- Commits ALU flags only when the checker's CondEx allows it, and gates the E-stage write enables (RegWrite, MemWrite, PCSrc).
- Runs a branch-penalty state machine that requests a pipeline flush and squashes younger instructions after a taken branch.

Parameters:
- FLAG_W, 4, flag register width; bit order [3]=N, [2]=Z, [1]=C, [0]=V.
- BRANCH_PENALTY, 2, number of squash cycles after a taken branch; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Stall  input  1  E stage held; no state change except reset.
- ALUFlags  input  FLAG_W  flags produced by the ALU this cycle.
- FlagWriteE  input  2  [1] writes N,Z; [0] writes C,V.
- CondEx  input  1  condition result from the condition checker for the current E instruction.
- RegWriteE  input  1  decoded register write enable.
- MemWriteE  input  1  decoded memory write enable.
- BranchE  input  1  current E instruction is a branch.
- Flags  output  FLAG_W  current flag register value, to the condition checker.
- RegWriteG  output  1  gated register write.
- MemWriteG  output  1  gated memory write.
- PCSrcG  output  1  taken-branch redirect.
- FlushReq  output  1  squash younger stages.
- Squashing  output  1  state == FLUSH.

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state:
  - Flags = 0.
  - State = IDLE, counter = 0.
  - All outputs 0 by the next cycle.
  - Reset during FLUSH aborts the penalty.
- Definitions:
  - Valid = !Squashing.
  - Commit = Valid && CondEx && !Stall.
- Flag update on a rising edge with Commit=1:
  - Flags[3:2] <= ALUFlags[3:2] if FlagWriteE[1].
  - Flags[1:0] <= ALUFlags[1:0] if FlagWriteE[0].
  - Partial writes leave the other pair unchanged.
- Flag latency: 1 cycle. A new value is visible on Flags the cycle after the write.
- Gated outputs (combinational from current inputs and state):
  - RegWriteG = RegWriteE & CondEx & Valid.
  - MemWriteG = MemWriteE & CondEx & Valid.
  - PCSrcG = BranchE & CondEx & Valid & !Stall.
  - Under Stall, RegWriteG and MemWriteG still reflect the held instruction; downstream gates them with Stall.
- State machine, IDLE:
  - FlushReq = 0.
  - If PCSrcG=1: go to FLUSH, counter <= BRANCH_PENALTY-1, FlushReq = 1 combinationally in the same cycle as PCSrcG.
- State machine, FLUSH:
  - FlushReq = 1, Squashing = 1.
  - All gated outputs forced 0; flags frozen; branches ignored (squashed).
  - If !Stall: when counter == 0 go to IDLE, else counter <= counter-1.
  - Stall holds both counter and state.
- Total FlushReq high time: BRANCH_PENALTY+1 cycles (the branch cycle plus BRANCH_PENALTY FLUSH cycles), extended by any stall cycles.
- Counter width is $clog2(BRANCH_PENALTY+1); it must never wrap.
- Simultaneous events:
  - Stall and a taken branch in the same cycle: no redirect; re-evaluated when Stall drops.
  - Branch with FlagWriteE set: flags commit and the branch resolves on the same edge using the pre-write Flags.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: Flags output is forwarded. When Commit=1, the written pair(s) on Flags show ALUFlags combinationally in the same cycle (zero-latency forward to the checker). Register contents and timing are unchanged.
- Undefined: Flags is purely the register output, with 1-cycle latency.

Test Plan:
- Reset: rst=1 for 2 cycles with ALUFlags=4'b1111 and FlagWriteE=2'b11 -> Flags=4'b0000, FlushReq=0, Squashing=0.
- Conditional write: CondEx=1, FlagWriteE=2'b10, ALUFlags=4'b0100 -> next cycle Flags=4'b0100. Then CondEx=0, ALUFlags=4'b1011 -> Flags stays 4'b0100, RegWriteG=0 with RegWriteE=1.
- Partial write: Flags=4'b0100, FlagWriteE=2'b01, ALUFlags=4'b1011, CondEx=1 -> Flags=4'b0111.
- Taken branch, BRANCH_PENALTY=2: BranchE=1, CondEx=1 -> PCSrcG=1 and FlushReq=1 that cycle; FlushReq stays 1 for 2 more cycles; MemWriteE=1 during FLUSH gives MemWriteG=0; IDLE on cycle 4.
- Stall in FLUSH: Stall=1 for 3 cycles mid-penalty -> FlushReq held high, counter frozen, total high time 3+3=6 cycles. rst=1 mid-FLUSH -> IDLE and FlushReq=0 the next cycle.
- With FLAG_BYPASS_EN: Commit with FlagWriteE=2'b11, ALUFlags=4'b1001 -> Flags=4'b1001 the same cycle. Without the macro, Flags=4'b1001 only on the next cycle.

Source files
------------

// File: rtl/cond_flag_register.sv
// rtl/cond_flag_register.sv - NZCV flag register, write-enable gating and branch-penalty flush FSM
// Optional feature macro: FLAG_BYPASS_EN (zero-latency forward of committed flags onto Flags)
module cond_flag_register #(
    parameter int FLAG_W         = 4,
    parameter int BRANCH_PENALTY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagWriteE,
    input  logic              CondEx,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    output logic [FLAG_W-1:0] Flags,
    output logic              RegWriteG,
    output logic              MemWriteG,
    output logic              PCSrcG,
    output logic              FlushReq,
    output logic              Squashing
);

    // Counter is sized to hold BRANCH_PENALTY-1 and only ever counts down to zero.
    localparam int              CNT_W    = $clog2(BRANCH_PENALTY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BRANCH_PENALTY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [FLAG_W-1:0] flags_q;
    logic              valid;
    logic              commit;

    // An instruction is live only outside the squash window; it commits when its condition holds and E is not held.
    assign valid  = (state == IDLE);
    assign commit = valid & CondEx & ~Stall;

    assign RegWriteG = RegWriteE & CondEx & valid;
    assign MemWriteG = MemWriteE & CondEx & valid;
    assign PCSrcG    = BranchE & CondEx & valid & ~Stall;
    assign Squashing = (state == FLUSH);
    assign FlushReq  = Squashing | PCSrcG;

    // Flag register: N/Z and C/V pairs are written independently on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (commit) begin
            if (FlagWriteE[1]) flags_q[FLAG_W-1:FLAG_W-2] <= ALUFlags[FLAG_W-1:FLAG_W-2];
            if (FlagWriteE[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Flags seen by the condition checker: register value, optionally overlaid with this cycle's committed pairs.
    always_comb begin
        Flags = flags_q;
`ifdef FLAG_BYPASS_EN
        if (commit && FlagWriteE[1]) Flags[FLAG_W-1:FLAG_W-2] = ALUFlags[FLAG_W-1:FLAG_W-2];
        if (commit && FlagWriteE[0]) Flags[1:0] = ALUFlags[1:0];
`endif
    end

    // Branch-penalty FSM: a taken branch opens a squash window of BRANCH_PENALTY unstalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PCSrcG) begin
                        state <= FLUSH;
                        cnt   <= CNT_LOAD;
                    end
                end
                FLUSH: begin
                    if (!Stall) begin
                        if (cnt == '0) state <= IDLE;
                        else           cnt   <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cond_flag_register.sv
// tb/tb_cond_flag_register.sv - randomized self-checking bench for cond_flag_register
module tb_cond_flag_register;

    localparam int BP = 2;

    logic       clk = 1'b0;
    logic       rst, Stall, CondEx, RegWriteE, MemWriteE, BranchE;
    logic [3:0] ALUFlags;
    logic [1:0] FlagWriteE;
    logic [3:0] Flags;
    logic       RegWriteG, MemWriteG, PCSrcG, FlushReq, Squashing;

    int n_vec  = 0;
    int n_fail = 0;

    cond_flag_register #(.FLAG_W(4), .BRANCH_PENALTY(BP)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .ALUFlags(ALUFlags), .FlagWriteE(FlagWriteE),
        .CondEx(CondEx), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .Flags(Flags), .RegWriteG(RegWriteG), .MemWriteG(MemWriteG), .PCSrcG(PCSrcG),
        .FlushReq(FlushReq), .Squashing(Squashing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural flags plus number of squash cycles still owed.
    logic [3:0] m_flags;
    int         m_rem   = 0;
    bit         m_ok    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_flags = 4'b0000;
            m_rem   = 0;
            m_ok    = 1;
        end else if (m_rem > 0) begin
            if (!Stall) m_rem = m_rem - 1;
        end else if (CondEx && !Stall) begin
            if (FlagWriteE[1]) m_flags = {ALUFlags[3:2], m_flags[1:0]};
            if (FlagWriteE[0]) m_flags = {m_flags[3:2], ALUFlags[1:0]};
            if (BranchE) m_rem = BP;
        end
    end

    // Every cycle: outputs must follow from the model state and the current inputs.
    always @(negedge clk) begin
        if (m_ok) begin
            bit         live;
            bit         pc;
            logic [3:0] ef;
            live = (m_rem == 0);
            pc   = BranchE && CondEx && live && !Stall;
            ef   = m_flags;
`ifdef FLAG_BYPASS_EN
            if (live && CondEx && !Stall) begin
                if (FlagWriteE[1]) ef[3:2] = ALUFlags[3:2];
                if (FlagWriteE[0]) ef[1:0] = ALUFlags[1:0];
            end
`endif
            chk("cyc_flags", Flags, ef);
            chk("cyc_regwrite", {3'b0, RegWriteG}, {3'b0, RegWriteE && CondEx && live});
            chk("cyc_memwrite", {3'b0, MemWriteG}, {3'b0, MemWriteE && CondEx && live});
            chk("cyc_pcsrc", {3'b0, PCSrcG}, {3'b0, pc});
            chk("cyc_flushreq", {3'b0, FlushReq}, {3'b0, !live || pc});
            chk("cyc_squashing", {3'b0, Squashing}, {3'b0, !live});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;
        rst = 1'b1; Stall = 1'b0; CondEx = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0;
        BranchE = 1'b0; ALUFlags = 4'b1111; FlagWriteE = 2'b11;
        tick(); tick();
        chk("reset_flags", Flags, 4'b0000);
        chk("reset_flushreq", {3'b0, FlushReq}, 4'b0);
        chk("reset_squashing", {3'b0, Squashing}, 4'b0);

        rst = 1'b0; CondEx = 1'b1; FlagWriteE = 2'b10; ALUFlags = 4'b0100;
        tick();
        chk("cond_write", Flags, 4'b0100);
        CondEx = 1'b0; ALUFlags = 4'b1011; RegWriteE = 1'b1; FlagWriteE = 2'b11;
        #1;
        chk("regwrite_gated", {3'b0, RegWriteG}, 4'b0);
        tick();
        chk("cond_false_hold", Flags, 4'b0100);

        CondEx = 1'b1; FlagWriteE = 2'b01; ALUFlags = 4'b1011; RegWriteE = 1'b0;
        tick();
        chk("partial_write", Flags, 4'b0111);

        FlagWriteE = 2'b00; BranchE = 1'b1; CondEx = 1'b1;
        #1;
        chk("branch_pcsrc", {3'b0, PCSrcG}, 4'b1);
        chk("branch_flushreq", {3'b0, FlushReq}, 4'b1);
        tick();
        BranchE = 1'b0; MemWriteE = 1'b1;
        #1;
        chk("flush1_req", {3'b0, FlushReq}, 4'b1);
        chk("flush1_squash", {3'b0, Squashing}, 4'b1);
        chk("flush1_memwrite", {3'b0, MemWriteG}, 4'b0);
        tick();
        chk("flush2_req", {3'b0, FlushReq}, 4'b1);
        tick();
        chk("idle_req", {3'b0, FlushReq}, 4'b0);
        chk("idle_memwrite", {3'b0, MemWriteG}, 4'b1);
        MemWriteE = 1'b0;

        hi = 0;
        for (int i = 0; i < 20; i++) begin
            BranchE = (i == 0);
            Stall   = (i >= 1 && i <= 3);
            #1;
            if (FlushReq) hi++;
            @(posedge clk);
            #1;
        end
        chk("stall_flush_len", 4'(hi), 4'd6);

        BranchE = 1'b1;
        tick();
        BranchE = 1'b0;
        #1;
        chk("mid_flush_squash", {3'b0, Squashing}, 4'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_flushreq", {3'b0, FlushReq}, 4'b0);
        chk("abort_squash", {3'b0, Squashing}, 4'b0);
        chk("abort_flags", Flags, 4'b0000);

        CondEx = 1'b1; FlagWriteE = 2'b11; ALUFlags = 4'b1001;
        #1;
`ifdef FLAG_BYPASS_EN
        chk("bypass_same_cycle", Flags, 4'b1001);
`else
        chk("bypass_same_cycle", Flags, 4'b0000);
`endif
        tick();
        chk("bypass_next_cycle", Flags, 4'b1001);
        FlagWriteE = 2'b00;

        Stall = 1'b1; BranchE = 1'b1; CondEx = 1'b1;
        #1;
        chk("stall_branch_pcsrc", {3'b0, PCSrcG}, 4'b0);
        chk("stall_branch_flush", {3'b0, FlushReq}, 4'b0);
        tick();
        Stall = 1'b0;
        #1;
        chk("unstall_branch_pcsrc", {3'b0, PCSrcG}, 4'b1);
        tick();

        for (int i = 0; i < 2000; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            Stall      = ($urandom_range(0, 3) == 0);
            CondEx     = ($urandom_range(0, 3) != 0);
            RegWriteE  = $urandom_range(0, 1) == 1;
            MemWriteE  = $urandom_range(0, 1) == 1;
            BranchE    = ($urandom_range(0, 7) == 0);
            ALUFlags   = 4'($urandom);
            FlagWriteE = 2'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
